// File: rtl/vram_dma_loader.sv
// -----------------------------------------------------------------------------
// vram_dma_loader
//
// Bus-master loader that copies `length` bytes from a synchronous source memory
// into one of NUM_REGIONS video RAM regions over a Z80-style write bus. Each
// byte is read from the source, held until the video core releases VRAM
// (vram_busy low), then written with an active-low strobe. A write that
// overlaps vram_busy is retried with the same address and data.
//
// Ports:
//   clk, rst_n        clock; reset is asynchronous and ACTIVE-HIGH despite the
//                     name (matches the existing codebase)
//   start             one-cycle request, sampled only while idle
//   region/base_addr/length   transfer descriptor, latched on an accepted start
//   abort             cancel the transfer in progress
//   src_addr/src_rd   source read address (transfer index) and read strobe
//   src_data          source data, valid RD_LATENCY cycles after src_rd
//   vram_busy         video core owns VRAM; no write may commit
//   bus_addr/bus_dout/bus_wrn/bus_rdn   write bus (bus_rdn is always 1)
//   region_ena        one-hot region select, only asserted with bus_wrn=0
//   busy/done/aborted/err   status; done/aborted/err are one-cycle pulses
// -----------------------------------------------------------------------------
module vram_dma_loader #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int LEN_W       = 11,
    parameter int NUM_REGIONS = 2,
    parameter int RD_LATENCY  = 1,
    localparam int RGN_W      = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [RGN_W-1:0]       region,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [LEN_W-1:0]       length,
    input  logic                   abort,
    output logic [LEN_W-1:0]       src_addr,
    output logic                   src_rd,
    input  logic [DATA_W-1:0]      src_data,
    input  logic                   vram_busy,
    output logic [ADDR_W-1:0]      bus_addr,
    output logic [DATA_W-1:0]      bus_dout,
    output logic                   bus_wrn,
    output logic                   bus_rdn,
    output logic [NUM_REGIONS-1:0] region_ena,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic                   err
);

    localparam int CNT_W = 3;  // enough for RD_LATENCY up to 4

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_ARB,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [RGN_W-1:0]       rgn_q, rgn_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0]      data_q, data_d;

    logic [LEN_W-1:0]       src_addr_q, src_addr_d;
    logic                   src_rd_q, src_rd_d;
    logic [ADDR_W-1:0]      bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]      bus_dout_q, bus_dout_d;
    logic                   bus_wrn_q, bus_wrn_d;
    logic [NUM_REGIONS-1:0] region_ena_q, region_ena_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   aborted_q, aborted_d;
    logic                   err_q, err_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        rgn_d      = rgn_q;
        base_d     = base_q;
        len_d      = len_q;
        idx_d      = idx_q;
        wait_cnt_d = wait_cnt_q;
        data_d     = data_q;
        aborted_d  = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != '0 && int'(region) < NUM_REGIONS) begin
                        rgn_d   = region;
                        base_d  = base_addr;
                        len_d   = length;
                        idx_d   = '0;
                        state_d = S_READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // The last WAIT cycle is the one in which src_data is valid.
                if (wait_cnt_q == CNT_W'(RD_LATENCY - 1)) begin
                    data_d  = src_data;
                    state_d = S_ARB;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_ARB: begin
                if (!vram_busy) state_d = S_WRITE;
            end
            S_WRITE: begin
                // vram_busy at the closing edge voids the write: retry same idx.
                if (vram_busy) begin
                    state_d = S_ARB;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = (idx_d == len_q) ? S_DONE : S_READ;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including an accepted-looking commit.
        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            idx_d     = idx_q;
            aborted_d = 1'b1;
        end

        // Outputs are decoded from the next state so they are registered
        // and line up exactly with the state they belong to.
        busy_d       = (state_d == S_READ) || (state_d == S_WAIT) ||
                       (state_d == S_ARB)  || (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
        src_rd_d     = (state_d == S_READ);
        src_addr_d   = (state_d == S_READ) ? idx_d : src_addr_q;
        bus_wrn_d    = (state_d != S_WRITE);
        region_ena_d = (state_d == S_WRITE) ? (NUM_REGIONS'(1) << rgn_d) : '0;
        bus_addr_d   = (state_d == S_WRITE) ? (base_d + ADDR_W'(idx_d)) : bus_addr_q;
        bus_dout_d   = (state_d == S_WRITE) ? data_d : bus_dout_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= S_IDLE;
            rgn_q        <= '0;
            base_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            wait_cnt_q   <= '0;
            data_q       <= '0;
            src_addr_q   <= '0;
            src_rd_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_dout_q   <= '0;
            bus_wrn_q    <= 1'b1;
            region_ena_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rgn_q        <= rgn_d;
            base_q       <= base_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            wait_cnt_q   <= wait_cnt_d;
            data_q       <= data_d;
            src_addr_q   <= src_addr_d;
            src_rd_q     <= src_rd_d;
            bus_addr_q   <= bus_addr_d;
            bus_dout_q   <= bus_dout_d;
            bus_wrn_q    <= bus_wrn_d;
            region_ena_q <= region_ena_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            err_q        <= err_d;
        end
    end

    assign src_addr   = src_addr_q;
    assign src_rd     = src_rd_q;
    assign bus_addr   = bus_addr_q;
    assign bus_dout   = bus_dout_q;
    assign bus_wrn    = bus_wrn_q;
    assign bus_rdn    = 1'b1;
    assign region_ena = region_ena_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign err        = err_q;

endmodule

// File: tb/tb_vram_dma_loader.sv
`timescale 1ns/1ps
// Bench for vram_dma_loader. Two instances: index 0 uses the defaults
// (2 regions, read latency 1); index 1 uses 3 regions and read latency 3 so
// address wrap, longer latency and an out-of-range region can be exercised.
module tb_vram_dma_loader;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [2:0]  ena;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_v  [2];
    logic        abort_v  [2];
    logic        vbusy_v  [2];
    logic [1:0]  region_v [2];
    logic [15:0] base_v   [2];
    logic [10:0] len_v    [2];
    logic [7:0]  key_v    [2];

    logic [10:0] saddr_v  [2];
    logic        srd_v    [2];
    logic [15:0] addr_v   [2];
    logic [7:0]  dout_v   [2];
    logic        wrn_v    [2];
    logic        rdn_v    [2];
    logic        busy_o   [2];
    logic        done_v   [2];
    logic        abrt_v   [2];
    logic        err_v    [2];
    logic [1:0]  ena_a;
    logic [2:0]  ena_b;
    logic [2:0]  ena_v    [2];
    logic [7:0]  src_data_a;
    logic [7:0]  src_data_b;

    assign ena_v[0] = {1'b0, ena_a};
    assign ena_v[1] = ena_b;

    vram_dma_loader dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .region(region_v[0][0]),
        .base_addr(base_v[0]), .length(len_v[0]), .abort(abort_v[0]),
        .src_addr(saddr_v[0]), .src_rd(srd_v[0]), .src_data(src_data_a),
        .vram_busy(vbusy_v[0]), .bus_addr(addr_v[0]), .bus_dout(dout_v[0]),
        .bus_wrn(wrn_v[0]), .bus_rdn(rdn_v[0]), .region_ena(ena_a),
        .busy(busy_o[0]), .done(done_v[0]), .aborted(abrt_v[0]), .err(err_v[0])
    );

    vram_dma_loader #(.NUM_REGIONS(3), .RD_LATENCY(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .region(region_v[1]),
        .base_addr(base_v[1]), .length(len_v[1]), .abort(abort_v[1]),
        .src_addr(saddr_v[1]), .src_rd(srd_v[1]), .src_data(src_data_b),
        .vram_busy(vbusy_v[1]), .bus_addr(addr_v[1]), .bus_dout(dout_v[1]),
        .bus_wrn(wrn_v[1]), .bus_rdn(rdn_v[1]), .region_ena(ena_b),
        .busy(busy_o[1]), .done(done_v[1]), .aborted(abrt_v[1]), .err(err_v[1])
    );

    // Source memories: source[j] = j[7:0] ^ key, returned RD_LATENCY cycles
    // after the read strobe; any cycle without a read returns junk (EE).
    logic [7:0] pipe_a;
    logic [7:0] pipe_b [3];
    always @(posedge clk) begin
        pipe_a    <= srd_v[0] ? (saddr_v[0][7:0] ^ key_v[0]) : 8'hEE;
        pipe_b[0] <= srd_v[1] ? (saddr_v[1][7:0] ^ key_v[1]) : 8'hEE;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign src_data_a = pipe_a;
    assign src_data_b = pipe_b[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  n_cmp  = 0;
    int  n_fail = 0;
    wr_t exp_q [2][$];
    int  commit_cyc [2][$];
    int  commits  [2] = '{0, 0};
    int  attempts [2] = '{0, 0};
    int  retries  [2] = '{0, 0};
    int  done_cnt [2] = '{0, 0};
    int  abrt_cnt [2] = '{0, 0};
    int  err_cnt  [2] = '{0, 0};
    int  done_cyc [2] = '{0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard. Inputs change 1ns after posedge, so vram_busy and
    // abort seen here are the values the DUT samples at the next edge.
    always @(negedge clk) begin
        wr_t e;
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                if (wrn_v[s] && ena_v[s] != 3'd0)
                    check($sformatf("ena_without_wrn[%0d]", s), 32'(ena_v[s]), 32'd0);
                if (!wrn_v[s]) begin
                    attempts[s]++;
                    if (vbusy_v[s] || abort_v[s]) begin
                        retries[s]++;
                    end else begin
                        commits[s]++;
                        commit_cyc[s].push_back(cyc);
                        if (exp_q[s].size() == 0) begin
                            check($sformatf("extra_write_addr[%0d]", s), 32'(addr_v[s]), 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q[s].pop_front();
                            check($sformatf("wr_addr[%0d]", s), 32'(addr_v[s]), 32'(e.addr));
                            check($sformatf("wr_data[%0d]", s), 32'(dout_v[s]), 32'(e.data));
                            check($sformatf("wr_ena[%0d]",  s), 32'(ena_v[s]),  32'(e.ena));
                        end
                    end
                end
                if (done_v[s]) begin
                    done_cnt[s]++;
                    done_cyc[s] = cyc;
                end
                if (abrt_v[s]) abrt_cnt[s]++;
                if (err_v[s])  err_cnt[s]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a start and pushes the hand-derived write sequence.
    task automatic start_xfer(input int s, input logic [1:0] rgn, input logic [15:0] base,
                              input logic [10:0] len, input logic [7:0] key, output int t0);
        wr_t e;
        key_v[s]    = key;
        region_v[s] = rgn;
        base_v[s]   = base;
        len_v[s]    = len;
        start_v[s]  = 1'b1;
        t0          = cyc;
        for (int j = 0; j < int'(len); j++) begin
            e.addr = base + 16'(j);
            e.data = key ^ 8'(j);
            e.ena  = 3'(1) << rgn;
            exp_q[s].push_back(e);
        end
        tick();
        start_v[s] = 1'b0;
    endtask

    task automatic wait_done(input int s, input int target, input int budget);
        int n = 0;
        while (done_cnt[s] < target && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt[s] < target)
            check($sformatf("timeout_done[%0d]", s), 32'(done_cnt[s]), 32'(target));
    endtask

    initial begin
        int t0, c0, a0, e0, d0, n;
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            start_v[s] = 1'b0; abort_v[s] = 1'b0; vbusy_v[s] = 1'b0;
            region_v[s] = '0; base_v[s] = '0; len_v[s] = '0; key_v[s] = '0;
        end
        repeat (3) tick();

        // Reset values, both instances.
        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst_wrn[%0d]", s),     32'(wrn_v[s]),   32'd1);
            check($sformatf("rst_rdn[%0d]", s),     32'(rdn_v[s]),   32'd1);
            check($sformatf("rst_addr[%0d]", s),    32'(addr_v[s]),  32'd0);
            check($sformatf("rst_dout[%0d]", s),    32'(dout_v[s]),  32'd0);
            check($sformatf("rst_ena[%0d]", s),     32'(ena_v[s]),   32'd0);
            check($sformatf("rst_src_rd[%0d]", s),  32'(srd_v[s]),   32'd0);
            check($sformatf("rst_src_adr[%0d]", s), 32'(saddr_v[s]), 32'd0);
            check($sformatf("rst_busy[%0d]", s),    32'(busy_o[s]),  32'd0);
            check($sformatf("rst_done[%0d]", s),    32'(done_v[s]),  32'd0);
            check($sformatf("rst_abrt[%0d]", s),    32'(abrt_v[s]),  32'd0);
            check($sformatf("rst_err[%0d]", s),     32'(err_v[s]),   32'd0);
        end
        rst_n = 1'b0;
        repeat (2) tick();

        // Basic load: region 0, 1024 bytes of j&FF, 4 cycles per byte. done
        // rises 4096 cycles after the edge that samples start (t0+1).
        start_xfer(0, 2'd0, 16'h0000, 11'h400, 8'h00, t0);
        wait_done(0, 1, 5000);
        check("t1_done_latency", 32'(done_cyc[0] - (t0 + 1)), 32'd4096);
        check("t1_commits", 32'(commits[0]), 32'd1024);
        check("t1_done_cnt", 32'(done_cnt[0]), 32'd1);

        // Second region back-to-back, with a start while busy thrown in.
        start_xfer(0, 2'd1, 16'h0000, 11'h400, 8'h5A, t0);
        repeat (100) tick();
        start_v[0] = 1'b1; region_v[0] = 2'd0; base_v[0] = 16'h1234; len_v[0] = 11'd5;
        tick();
        start_v[0] = 1'b0;
        wait_done(0, 2, 5000);
        check("t2_err_on_busy_start", 32'(err_cnt[0]), 32'd0);
        check("t2_commits", 32'(commits[0]), 32'd2048);
        check("t2_queue_empty", 32'(exp_q[0].size()), 32'd0);

        // Busy arbitration: vram_busy 5 high / 3 low, phased so the first ARB
        // sees the last low cycle and its WRITE overlaps busy (forced retry).
        c0 = commits[0];
        r_phase: begin
            int r0;
            r0 = retries[0];
            vbusy_v[0] = 1'b1;
            start_xfer(0, 2'd1, 16'h2000, 11'd16, 8'h33, t0);
            n = 1;
            while (done_cnt[0] < 3 && n < 600) begin
                vbusy_v[0] = (((n + 7) % 8) >= 3);
                tick();
                n++;
            end
            vbusy_v[0] = 1'b0;
            if (done_cnt[0] < 3) check("timeout_done_t3", 32'(done_cnt[0]), 32'd3);
            check("t3_commits", 32'(commits[0] - c0), 32'd16);
            check("t3_retry_seen", 32'(retries[0] - r0 > 0), 32'd1);
        end

        // Wrap and latency on instance 1: FFFE..0001, 6 cycles per byte.
        commit_cyc[1].delete();
        start_xfer(1, 2'd2, 16'hFFFE, 11'd4, 8'hC0, t0);
        wait_done(1, 1, 200);
        check("t4_done_latency", 32'(done_cyc[1] - (t0 + 1)), 32'd24);
        check("t4_commit_cnt", 32'(commit_cyc[1].size()), 32'd4);
        if (commit_cyc[1].size() == 4)
            for (int i = 1; i < 4; i++)
                check($sformatf("t4_spacing_%0d", i),
                      32'(commit_cyc[1][i] - commit_cyc[1][i-1]), 32'd6);

        // Rejects: zero length on instance 0, region 3 of 3 on instance 1.
        a0 = attempts[0]; e0 = err_cnt[0];
        len_v[0] = 11'd0; region_v[0] = 2'd0; start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        check("t5_len0_busy", 32'(busy_o[0]), 32'd0);
        repeat (5) tick();
        check("t5_len0_err", 32'(err_cnt[0] - e0), 32'd1);
        check("t5_len0_nowrite", 32'(attempts[0] - a0), 32'd0);
        a0 = attempts[1]; e0 = err_cnt[1];
        len_v[1] = 11'd4; region_v[1] = 2'd3; start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        check("t5_rgn_busy", 32'(busy_o[1]), 32'd0);
        repeat (5) tick();
        check("t5_rgn_err", 32'(err_cnt[1] - e0), 32'd1);
        check("t5_rgn_nowrite", 32'(attempts[1] - a0), 32'd0);

        // Abort after the 10th committed write of a 100-byte transfer.
        c0 = commits[0]; d0 = done_cnt[0]; e0 = abrt_cnt[0];
        start_xfer(0, 2'd0, 16'h0100, 11'd100, 8'h11, t0);
        n = 0;
        while (commits[0] - c0 < 10 && n < 200) begin
            tick();
            n++;
        end
        if (commits[0] - c0 < 10) check("timeout_t6_commits", 32'(commits[0] - c0), 32'd10);
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        check("t6_aborted_pulse", 32'(abrt_v[0]), 32'd1);
        check("t6_busy_low", 32'(busy_o[0]), 32'd0);
        a0 = attempts[0];
        repeat (30) tick();
        check("t6_commits", 32'(commits[0] - c0), 32'd10);
        check("t6_no_more_writes", 32'(attempts[0] - a0), 32'd0);
        check("t6_no_done", 32'(done_cnt[0] - d0), 32'd0);
        check("t6_abort_cnt", 32'(abrt_cnt[0] - e0), 32'd1);
        exp_q[0].delete();
        start_xfer(0, 2'd1, 16'h0200, 11'd3, 8'h77, t0);
        wait_done(0, d0 + 1, 100);
        check("t6_restart_queue", 32'(exp_q[0].size()), 32'd0);

        repeat (3) tick();
        check("final_queue0", 32'(exp_q[0].size()), 32'd0);
        check("final_queue1", 32'(exp_q[1].size()), 32'd0);
        check("final_abrt1", 32'(abrt_cnt[1]), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_dma_loader.md
Name: vram_dma_loader

Overview:
- Parametrised bus-master loader that copies a block of bytes from a synchronous source memory into one of NUM_REGIONS video RAM regions (tile, object, palette, ...).
- Each region is selected by its own enable strobe on the Z80-style write bus, and every write is arbitrated against vram_busy from the video core.
- Replaces the ad-hoc per-region load loops used for tile and object RAM. Supports arbitrary region count, base address, length and source read latency, and provides start/done/abort handshakes.

Parameters:
- ADDR_W, 16, width of bus_addr and base_addr.
- DATA_W, 8, width of source and bus data.
- LEN_W, 11, width of length and transfer index (max length 2^LEN_W - 1).
- NUM_REGIONS, 2, number of region enable strobes.
- RD_LATENCY, 1, cycles from src_rd to valid src_data (legal range 1..4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset (asynchronous, active-high).
- start  in  1  one-cycle request; sampled only in IDLE.
- region  in  $clog2(NUM_REGIONS) (min 1)  target region index, latched at start.
- base_addr  in  ADDR_W  first bus address, latched at start.
- length  in  LEN_W  byte count, latched at start.
- abort  in  1  cancel the transfer in progress.
- src_addr  out  LEN_W  source read address (= transfer index).
- src_rd  out  1  one-cycle source read strobe.
- src_data  in  DATA_W  source data, valid RD_LATENCY cycles after src_rd.
- vram_busy  in  1  video core owns VRAM; writes are not allowed.
- bus_addr  out  ADDR_W  write address.
- bus_dout  out  DATA_W  write data.
- bus_wrn  out  1  active-low write strobe.
- bus_rdn  out  1  tied 1 (loader never reads).
- region_ena  out  NUM_REGIONS  one-hot region select, asserted only with bus_wrn=0.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse on successful completion.
- aborted  out  1  one-cycle pulse when abort takes effect.
- err  out  1  one-cycle pulse when a start request is rejected.

Behaviour:
- Reset values (reset asserted, asynchronous):
  - bus_wrn=1, bus_rdn=1.
  - bus_addr=0, bus_dout=0, region_ena=0.
  - src_rd=0, src_addr=0.
  - busy=done=aborted=err=0.
  - FSM in IDLE.
- All outputs are registered.

FSM states:
- IDLE:
  - start=1 with length!=0 and region<NUM_REGIONS: latch region/base/length, idx=0, busy=1, go to READ.
  - start=1 with length==0 or region>=NUM_REGIONS: err=1 next cycle, remain IDLE.
- READ: src_rd=1 and src_addr=idx for exactly one cycle, then go to WAIT.
- WAIT:
  - Count RD_LATENCY cycles after the src_rd cycle.
  - Capture src_data into the data register on the cycle it is valid.
  - Then go to ARB.
- ARB: when vram_busy==0 is sampled, go to WRITE; otherwise hold.
- WRITE (one cycle):
  - Drive bus_wrn=0, bus_addr=(base+idx) mod 2^ADDR_W, bus_dout=data, region_ena=1<<region.
  - If vram_busy==1 at the edge ending WRITE: the write is not committed; deassert strobes, go to ARB, and retry the same idx with the same data.
  - Otherwise the write is committed; idx++.
  - If idx==length, go to DONE; else go to READ.
- DONE: done=1 and busy=0 for one cycle, then IDLE.

Rules and boundary conditions:
- Address arithmetic wraps modulo 2^ADDR_W. Example: base=FFFE, length=3 writes FFFE, FFFF, 0000.
- Minimum cycles per byte with vram_busy low: 1 (READ) + RD_LATENCY (WAIT) + 1 (ARB) + 1 (WRITE). With RD_LATENCY=1 this is 4.
- Between writes, bus_wrn=1 and region_ena=0. bus_addr and bus_dout hold their last values.
- abort=1 in any non-IDLE state:
  - Next cycle: all strobes deasserted, busy=0, aborted=1, state IDLE.
  - A write in progress that cycle is not counted.
  - done is not pulsed.
  - abort in IDLE has no effect.
- abort and start in the same cycle while busy: abort wins and start is ignored.
- start while busy is ignored; no err pulse.
- Reset asserted mid-transfer: immediate return to reset values; no done or aborted pulse.

Test Plan:
- Basic load: region=0, base=0000, length=0x400, source[j]=j&FF, vram_busy=0.
  -> 1024 writes, addr=j, data=j&FF, region_ena=01 on each.
  -> done pulses once, 4096 cycles after start.
- Second region back-to-back: after done, start region=1, base=0000, length=0x400.
  -> 1024 writes with region_ena=10 only; tile region never re-strobed.
- Busy arbitration: vram_busy toggles 5 cycles high / 3 low, length=16.
  -> Exactly 16 committed writes, none with vram_busy=1 at the committing edge, data sequence intact, retries visible.
- Wrap and latency: RD_LATENCY=3, base=FFFE, length=4.
  -> Addrs FFFE, FFFF, 0000, 0001 with correct data; 6 cycles per byte.
- Abort mid-transfer: length=100, abort after the 10th committed write.
  -> aborted pulses, busy=0 next cycle, no further bus_wrn=0, no done.
  -> A new start then succeeds.
- Rejects: length=0 -> err pulse, no bus activity. region=2 with NUM_REGIONS=2 -> err pulse. start while busy -> no err, transfer unaffected.
